axil_reg_bank: RTL and testbench

- AXI-Lite slave register bank. It terminates the slave side of the shell's axi_lite interface (DATA_WIDTH=32, CHANNEL=1), which is driven by the host/XDMA AXI-Lite master.
- Exposes NUM_RW read/write control words to user logic and NUM_RO read-only status words sampled from user logic.
- Write and read channels are independent; each carries at most one outstanding transaction.

---
 rtl/axil_pkg.sv | 30 +++
 rtl/axi_lite.sv | 38 +++
 rtl/axil_reg_bank.sv | 130 +++++++++++++
 tb/tb_axil_reg_bank.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite register bank definitions: response codes, address
// classification and the byte-lane write merge.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {SEL_RW, SEL_RO, SEL_NONE} reg_sel_e;

  function automatic reg_sel_e decode(input logic [31:0] addr,
                                      input int unsigned num_rw,
                                      input int unsigned num_ro);
    logic [31:0] idx;
    idx = addr >> 2;
    if (idx < num_rw) return SEL_RW;
    if (idx < num_rw + num_ro) return SEL_RO;
    return SEL_NONE;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi_lite.sv
// AXI-Lite bus bundle shared between the host-side master and slave blocks.
interface axi_lite #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CHANNEL    = 1
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-Lite slave exposing NUM_RW control words and NUM_RO sampled status words.
// Write and read channels run independently, one outstanding transaction each.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int unsigned          NUM_RW = 8,
  parameter int unsigned          NUM_RO = 8,
  parameter logic [NUM_RW*32-1:0] RW_RST = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_lite.slave               s_axil,
  output logic [NUM_RW*32-1:0] ctrl_o,
  output logic [NUM_RW-1:0]    wr_pulse_o,
  input  logic [NUM_RO*32-1:0] stat_i
);

  logic                 aw_held, w_held;
  logic [31:0]          awaddr_q, wdata_q;
  logic [3:0]           wstrb_q;
  logic                 bvalid_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [31:0]          rdata_q;
  logic [NUM_RW*32-1:0] ctrl_q;
  logic [NUM_RW-1:0]    pulse_q;

  logic        awready, wready, arready;
  logic        aw_hs, w_hs, ar_hs, commit;
  reg_sel_e    wsel, rsel;
  logic [31:0] widx, ridx, rd_word;
  logic [1:0]  wr_resp, rd_resp;

  assign awready = !aw_held && !bvalid_q;
  assign wready  = !w_held && !bvalid_q;
  assign arready = !rvalid_q;

  assign aw_hs  = s_axil.awvalid && awready;
  assign w_hs   = s_axil.wvalid && wready;
  assign ar_hs  = s_axil.arvalid && arready;
  assign commit = aw_held && w_held;

  assign widx = awaddr_q >> 2;
  assign ridx = s_axil.araddr >> 2;
  assign wsel = decode(awaddr_q, NUM_RW, NUM_RO);
  assign rsel = decode(s_axil.araddr, NUM_RW, NUM_RO);

  always_comb begin
    wr_resp = RESP_DECERR;
    case (wsel)
      SEL_RW:  wr_resp = RESP_OKAY;
      SEL_RO:  wr_resp = RESP_SLVERR;
      default: wr_resp = RESP_DECERR;
    endcase
  end

  // Out-of-range reads fall through both loops and return zero.
  always_comb begin
    rd_word = '0;
    rd_resp = (rsel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
    for (int i = 0; i < NUM_RW; i++)
      if (ridx == 32'(i)) rd_word = ctrl_q[32*i +: 32];
    for (int j = 0; j < NUM_RO; j++)
      if (ridx == NUM_RW + 32'(j)) rd_word = stat_i[32*j +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      ctrl_q   <= RW_RST;
      pulse_q  <= '0;
    end else begin
      pulse_q <= '0;
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        for (int i = 0; i < NUM_RW; i++) begin
          if (wsel == SEL_RW && widx == 32'(i)) begin
            ctrl_q[32*i +: 32] <= merge_bytes(ctrl_q[32*i +: 32], wdata_q, wstrb_q);
            pulse_q[i]         <= 1'b1;
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          awaddr_q <= s_axil.awaddr;
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= s_axil.wdata;
          wstrb_q <= s_axil.wstrb;
        end
        if (bvalid_q && s_axil.bready) bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axil.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axil.awready = awready;
  assign s_axil.wready  = wready;
  assign s_axil.arready = arready;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign ctrl_o         = ctrl_q;
  assign wr_pulse_o     = pulse_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: one task per scenario with inline checks
// against hand-computed values.
module tb_axil_reg_bank;

  localparam logic [255:0] RST_IMG = {32'hA5A50007, 32'h0, 32'h0, 32'h0,
                                      32'h33330003, 32'h0, 32'h0, 32'h0};

  logic         clk;
  logic         rst_n;
  logic [255:0] ctrl_o;
  logic [7:0]   wr_pulse_o;
  logic [255:0] stat_i;
  logic [255:0] exp_ctrl;
  logic [7:0]   pulse_acc;
  int           checks;
  int           errors;

  axi_lite #(.DATA_WIDTH(32), .CHANNEL(1)) axil ();

  axil_reg_bank #(.NUM_RW(8), .NUM_RO(8), .RW_RST(RST_IMG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axil     (axil),
    .ctrl_o     (ctrl_o),
    .wr_pulse_o (wr_pulse_o),
    .stat_i     (stat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) pulse_acc = pulse_acc | wr_pulse_o;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, got;
    aw_done = 0; w_done = 0; got = 0; resp = 2'b01;
    axil.awaddr = a; axil.wdata = d; axil.wstrb = s;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1; axil.bready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (axil.awvalid && axil.awready) aw_done = 1;
      if (axil.wvalid && axil.wready) w_done = 1;
      if (axil.bvalid) begin got = 1; resp = axil.bresp; end
      tick();
      if (aw_done) axil.awvalid = 1'b0;
      if (w_done) axil.wvalid = 1'b0;
    end
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    ok = got;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    bit ar_done, got;
    ar_done = 0; got = 0; resp = 2'b01; data = 32'hXXXX_XXXX;
    axil.araddr = a; axil.arvalid = 1'b1; axil.rready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (axil.arvalid && axil.arready) ar_done = 1;
      if (axil.rvalid) begin got = 1; data = axil.rdata; resp = axil.rresp; end
      tick();
      if (ar_done) axil.arvalid = 1'b0;
    end
    axil.arvalid = 1'b0;
    ok = got;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    axil.awvalid = 0; axil.awaddr = 0; axil.awprot = 0;
    axil.wvalid = 0; axil.wdata = 0; axil.wstrb = 0; axil.bready = 0;
    axil.arvalid = 0; axil.araddr = 0; axil.arprot = 0; axil.rready = 0;
    stat_i = '0;
    stat_i[0*32 +: 32] = 32'hCAFE0001;
    stat_i[1*32 +: 32] = 32'h5555AAAA;
    stat_i[7*32 +: 32] = 32'h77770007;
    pulse_acc = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_o !== RST_IMG) begin errors++;
      $display("FAIL reset_ctrl: got %h expected %h", ctrl_o, RST_IMG); end
    checks++;
    if ({axil.awready, axil.wready, axil.arready} !== 3'b111) begin errors++;
      $display("FAIL reset_ready: got %b expected 111", {axil.awready, axil.wready, axil.arready}); end
    checks++;
    if ({axil.bvalid, axil.rvalid, axil.bresp, axil.rresp, wr_pulse_o} !== 14'h0 || axil.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp: bvalid %b rvalid %b bresp %b rresp %b pulse %b rdata %h expected all zero",
               axil.bvalid, axil.rvalid, axil.bresp, axil.rresp, wr_pulse_o, axil.rdata); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    exp_ctrl = RST_IMG;
  endtask

  task automatic test_write_basic();
    pulse_acc = '0;
    axil.awaddr = 32'h04; axil.wdata = 32'hDEADBEEF; axil.wstrb = 4'hF;
    axil.awvalid = 1; axil.wvalid = 1; axil.bready = 1;
    checks++;
    if ({axil.awready, axil.wready} !== 2'b11) begin errors++;
      $display("FAIL wb_ready: got %b expected 11", {axil.awready, axil.wready}); end
    tick();
    axil.awvalid = 0; axil.wvalid = 0;
    checks++;
    if (axil.bvalid !== 1'b0 || ctrl_o[32 +: 32] !== 32'h0) begin errors++;
      $display("FAIL wb_early: bvalid %b word1 %h expected 0 / 00000000", axil.bvalid, ctrl_o[32 +: 32]); end
    tick();
    exp_ctrl[32 +: 32] = 32'hDEADBEEF;
    checks++;
    if (ctrl_o !== exp_ctrl) begin errors++;
      $display("FAIL wb_ctrl: got %h expected %h", ctrl_o, exp_ctrl); end
    checks++;
    if (wr_pulse_o !== 8'b0000_0010 || axil.bvalid !== 1'b1 || axil.bresp !== 2'b00) begin errors++;
      $display("FAIL wb_commit: pulse %b bvalid %b bresp %b expected 00000010 1 00",
               wr_pulse_o, axil.bvalid, axil.bresp); end
    tick();
    checks++;
    if (wr_pulse_o !== 8'h0 || axil.bvalid !== 1'b0) begin errors++;
      $display("FAIL wb_after: pulse %b bvalid %b expected 0 0", wr_pulse_o, axil.bvalid); end
  endtask

  task automatic test_w_first();
    axil.wdata = 32'h11223344; axil.wstrb = 4'b0101; axil.wvalid = 1; axil.bready = 1;
    tick();
    axil.wvalid = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (axil.awready !== 1'b1 || axil.wready !== 1'b0 || axil.bvalid !== 1'b0) begin errors++;
        $display("FAIL wf_hold cycle %0d: awready %b wready %b bvalid %b expected 1 0 0",
                 c, axil.awready, axil.wready, axil.bvalid); end
      tick();
    end
    axil.awaddr = 32'h00; axil.awvalid = 1;
    tick();
    axil.awvalid = 0;
    tick();
    exp_ctrl[0 +: 32] = 32'h00220044;
    checks++;
    if (ctrl_o !== exp_ctrl || wr_pulse_o !== 8'b1 || axil.bvalid !== 1'b1 || axil.bresp !== 2'b00) begin
      errors++;
      $display("FAIL wf_commit: word0 %h pulse %b bvalid %b bresp %b expected 00220044 00000001 1 00",
               ctrl_o[0 +: 32], wr_pulse_o, axil.bvalid, axil.bresp); end
    tick();
  endtask

  task automatic test_ro_access();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_read(32'h20, d, r, ok);
    checks++;
    if (!ok || d !== 32'hCAFE0001 || r !== 2'b00) begin errors++;
      $display("FAIL ro_read: ok %0d data %h resp %b expected 1 cafe0001 00", ok, d, r); end
    pulse_acc = '0;
    axi_write(32'h20, 32'h12345678, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b10) begin errors++;
      $display("FAIL ro_write_resp: ok %0d resp %b expected 1 10", ok, r); end
    checks++;
    if (ctrl_o !== exp_ctrl || pulse_acc !== 8'h0) begin errors++;
      $display("FAIL ro_write_side: ctrl %h pulses %b expected %h 00000000", ctrl_o, pulse_acc, exp_ctrl); end
  endtask

  task automatic test_decode_edges();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_read(32'h40, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b11) begin errors++;
      $display("FAIL oor_read: ok %0d data %h resp %b expected 1 00000000 11", ok, d, r); end
    pulse_acc = '0;
    axi_write(32'h44, 32'hFFFFFFFF, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b11 || ctrl_o !== exp_ctrl || pulse_acc !== 8'h0) begin errors++;
      $display("FAIL oor_write: ok %0d resp %b pulses %b expected 1 11 00000000", ok, r, pulse_acc); end
    axi_read(32'h3C, d, r, ok);
    checks++;
    if (!ok || d !== 32'h77770007 || r !== 2'b00) begin errors++;
      $display("FAIL last_ro: ok %0d data %h resp %b expected 1 77770007 00", ok, d, r); end
    axi_read(32'h1F, d, r, ok);
    checks++;
    if (!ok || d !== 32'hA5A50007 || r !== 2'b00) begin errors++;
      $display("FAIL last_rw: ok %0d data %h resp %b expected 1 a5a50007 00", ok, d, r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; bit ok;
    axil.bready = 0; axil.rready = 0;
    axil.awaddr = 32'h0C; axil.wdata = 32'h0BADF00D; axil.wstrb = 4'hF;
    axil.araddr = 32'h24;
    axil.awvalid = 1; axil.wvalid = 1; axil.arvalid = 1;
    tick();
    axil.awvalid = 0; axil.wvalid = 0; axil.arvalid = 0;
    tick();
    stat_i[1*32 +: 32] = 32'h0F0F0F0F;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (axil.bvalid !== 1'b1 || axil.bresp !== 2'b00 || axil.rvalid !== 1'b1 ||
          axil.rdata !== 32'h5555AAAA || axil.rresp !== 2'b00 ||
          {axil.awready, axil.wready, axil.arready} !== 3'b000) begin errors++;
        $display("FAIL bp_hold cycle %0d: bvalid %b bresp %b rvalid %b rdata %h readies %b expected 1 00 1 5555aaaa 000",
                 c, axil.bvalid, axil.bresp, axil.rvalid, axil.rdata,
                 {axil.awready, axil.wready, axil.arready}); end
      tick();
    end
    axil.bready = 1; axil.rready = 1;
    tick();
    checks++;
    if (axil.bvalid !== 1'b0 || axil.rvalid !== 1'b0 ||
        {axil.awready, axil.wready, axil.arready} !== 3'b111) begin errors++;
      $display("FAIL bp_release: bvalid %b rvalid %b readies %b expected 0 0 111",
               axil.bvalid, axil.rvalid, {axil.awready, axil.wready, axil.arready}); end
    exp_ctrl[3*32 +: 32] = 32'h0BADF00D;
    axi_read(32'h0C, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0BADF00D || r !== 2'b00) begin errors++;
      $display("FAIL bp_next: ok %0d data %h resp %b expected 1 0badf00d 00", ok, d, r); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; bit ok;
    axi_write(32'h08, 32'h5, 4'hF, r, ok);
    exp_ctrl[2*32 +: 32] = 32'h5;
    axil.awaddr = 32'h08; axil.wdata = 32'h9; axil.wstrb = 4'hF;
    axil.awvalid = 1; axil.wvalid = 1; axil.bready = 0;
    tick();
    axil.awvalid = 0; axil.wvalid = 0;
    axil.araddr = 32'h08; axil.arvalid = 1; axil.rready = 0;
    tick();
    axil.arvalid = 0;
    exp_ctrl[2*32 +: 32] = 32'h9;
    checks++;
    if (axil.rvalid !== 1'b1 || axil.rdata !== 32'h5 || ctrl_o !== exp_ctrl || axil.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL coll_old: rvalid %b rdata %h word2 %h bvalid %b expected 1 00000005 00000009 1",
               axil.rvalid, axil.rdata, ctrl_o[2*32 +: 32], axil.bvalid); end
    axil.bready = 1; axil.rready = 1;
    tick();
    axi_read(32'h08, d, r, ok);
    checks++;
    if (!ok || d !== 32'h9 || r !== 2'b00) begin errors++;
      $display("FAIL coll_new: ok %0d data %h resp %b expected 1 00000009 00", ok, d, r); end
  endtask

  task automatic test_reset_mid();
    axil.bready = 1;
    axil.awaddr = 32'h04; axil.awvalid = 1;
    tick();
    axil.awvalid = 0;
    checks++;
    if (axil.awready !== 1'b0) begin errors++;
      $display("FAIL rm_held: awready %b expected 0", axil.awready); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_o !== RST_IMG || axil.bvalid !== 1'b0 || {axil.awready, axil.wready} !== 2'b11) begin errors++;
      $display("FAIL rm_async: ctrl %h bvalid %b readies %b expected %h 0 11",
               ctrl_o, axil.bvalid, {axil.awready, axil.wready}, RST_IMG); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ctrl = RST_IMG;
    pulse_acc = '0;
    axil.wdata = 32'hFFFFFFFF; axil.wstrb = 4'hF; axil.wvalid = 1;
    tick();
    axil.wvalid = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (axil.bvalid !== 1'b0 || ctrl_o !== exp_ctrl) begin errors++;
        $display("FAIL rm_stale cycle %0d: bvalid %b ctrl %h expected 0 %h", c, axil.bvalid, ctrl_o, exp_ctrl); end
      tick();
    end
    checks++;
    if (pulse_acc !== 8'h0) begin errors++;
      $display("FAIL rm_pulse: pulses %b expected 00000000", pulse_acc); end
    axil.awaddr = 32'h14; axil.awvalid = 1;
    tick();
    axil.awvalid = 0;
    tick();
    exp_ctrl[5*32 +: 32] = 32'hFFFFFFFF;
    checks++;
    if (axil.bvalid !== 1'b1 || axil.bresp !== 2'b00 || ctrl_o !== exp_ctrl || wr_pulse_o !== 8'b0010_0000) begin
      errors++;
      $display("FAIL rm_resume: bvalid %b bresp %b word5 %h pulse %b expected 1 00 ffffffff 00100000",
               axil.bvalid, axil.bresp, ctrl_o[5*32 +: 32], wr_pulse_o); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_basic();
    test_w_first();
    test_ro_access();
    test_decode_edges();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
